tanh_rr_arbiter: RTL and testbench
==================================

# tanh_rr_arbiter

Shares one combinational `Tanh` activation unit between `N_REQ` requesters, typically the hidden-neuron lanes of the RNN cell. It arbitrates round-robin, registers the winning operand, evaluates `Tanh`, and registers the result. The result is returned on one shared response channel, tagged with the requester ID. Sustained throughput is one activation per cycle, with backpressure on the response side.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 32: operand width. Input is Q17.15; output is Q1.15 sign-extended to `DATA_W`.
- `ID_W`, `$clog2(N_REQ)`: requester ID width.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, `N_REQ`: per-requester operand valid.
- `req_x`, input, `N_REQ*DATA_W`: packed Q17.15 operands. Requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ready`, output, `N_REQ`: one-hot (or zero) grant. Requester i's transfer happens when `req_valid[i] && req_ready[i]`.
- `rsp_valid`, output, 1: result valid.
- `rsp_ready`, input, 1: consumer accepts result.
- `rsp_y`, output, `DATA_W`: Q1.15 `tanh(x)` result.
- `rsp_id`, output, `ID_W`: index of the requester that issued the operand.
- `busy`, output, 1: `s1_valid | rsp_valid`.

## Operation
**Pipeline**
- Stage S1 holds `s1_valid`, `s1_x` and `s1_id`.
- `Tanh` is driven combinationally from `s1_x`.
- Stage S2 is the output register (`rsp_valid`, `rsp_y`, `rsp_id`).

**Stall logic**
- `adv = !rsp_valid || rsp_ready`.
- S2 loads from S1 when `adv`. `rsp_valid` then takes the value of `s1_valid`.
- `s1_free = !s1_valid || adv`.

**Arbitration**
- `ptr` holds the last granted index; its reset value is `N_REQ-1`.
- The search starts at `ptr+1` modulo `N_REQ`; the first requester with `req_valid` set wins.
- `req_ready` is the winner's one-hot vector, gated by `s1_free`.
- `req_ready` is combinational from `req_valid`, `ptr` and the pipeline state. It is all-zero when `s1_free` is 0 or no requester is valid.
- `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On a transfer, S1 loads the winner's x and ID, and `ptr` takes the winner's index.
- `ptr` is unchanged on cycles without a transfer.

**Values**
- Arithmetic is handled entirely inside `Tanh`; this block never modifies operand or result bits.
- A requester holding `req_valid` high is granted within `N_REQ` transfers.

**Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_y=0`, `rsp_id=0`, `busy=0`, `s1_valid=0`, `ptr=N_REQ-1`.

## Timing
- Latency from transfer at edge T: S1 loads at T and `rsp_valid` rises after edge T+1, a minimum of 2 cycles.
- With `rsp_ready` held high, one result is produced per cycle.
- **Stall:** while `rsp_valid && !rsp_ready`, the block must hold:
  - `rsp_*` stays stable.
  - S1 holds its contents.
  - If S1 is full, `req_ready=0`.
  - If S1 is empty, exactly one more operand may be accepted into S1.
- **Simultaneous events:** with `rsp_ready` high, a full S1 and a new transfer in the same cycle, S2 takes S1 and S1 takes the new operand. Nothing is lost or duplicated.
- **Reset mid-operation:** asserting `rst_n` low immediately clears S1, S2 and `ptr`. In-flight operands are discarded without a response. After `rst_n` deasserts, the first grant goes to the lowest valid index.
- **Pointer wrap:** after index `N_REQ-1` is granted, priority passes to index 0.

## Structure
- Shared package `rnn_fixed_pkg` holds:
  - `DATA_W`, `FRAC_BITS_IN=15` and `FRAC_BITS_OUT=15`.
  - Q-format constants `ONE_Q15 = 32768`.
- Sub-module `rr_picker`: combinational round-robin selector. Inputs are `req_valid` and `ptr`; outputs are the one-hot grant and the encoded index.
- The existing `Tanh` module is instantiated unchanged (ports `x`, `y`).

## Test plan
- **Single requester:** after reset, requester 2 presents x=0x00008000 (1.0) with `rsp_ready=1`. Then `rsp_valid` is high exactly 2 cycles after the transfer, `rsp_id=2`, and `rsp_y` equals a standalone `Tanh` reference output for the same x. x=0 must give `rsp_y=0`.
- **All requesters, continuous:** all 4 requesters hold `req_valid` high with distinct x. Grants occur in the order 0,1,2,3,0,… at one per cycle, and the `rsp_id` sequence matches the grant sequence.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles with all requesters valid. Exactly 2 operands are accepted and `rsp_y`/`rsp_id` stay stable. After release, results drain in order with no loss or duplication.
- **Saturation passthrough:** x=0x00040000 (8.0) and x=0xFFFC0000 (−8.0). `rsp_y` must match the reference `Tanh` output bit-exactly, which is its positive or negative saturation value.
- **Reset mid-flight:** pulse `rst_n` low while S1 and S2 are full. All outputs go to 0 asynchronously and no response follows. Afterwards, requesters 1 and 3 both valid are granted 1 first.
- **Fairness:** requester 0 valid continuously and requester 3 toggling. Requester 3 must never wait more than 2 grants while its `req_valid` is held.

Source files
------------

// File: rtl/rnn_fixed_pkg.sv
// Fixed-point formats shared by the RNN datapath blocks.
// Operands are Q17.15 and activation outputs are Q1.15, both carried in DATA_W bits.
package rnn_fixed_pkg;

    localparam int DATA_W        = 32;
    localparam int FRAC_BITS_IN  = 15;
    localparam int FRAC_BITS_OUT = 15;
    localparam int ONE_Q15       = 32768;

endpackage

// File: rtl/Tanh.sv
// Combinational tanh: Q17.15 operand in, Q1.15 result sign-extended to DATA_W.
// Odd-symmetric piecewise-linear curve on |x| built from shifts, saturating at 3.0.
module Tanh
    import rnn_fixed_pkg::*;
#(
    parameter int DATA_W = rnn_fixed_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] ONE_U   = DATA_W'(1 << FRAC_BITS_IN);
    localparam logic [DATA_W-1:0] TWO_U   = DATA_W'(2 << FRAC_BITS_IN);
    localparam logic [DATA_W-1:0] THREE_U = DATA_W'(3 << FRAC_BITS_IN);
    localparam logic [DATA_W-1:0] Y_AT_1  = DATA_W'((3 * ONE_Q15) / 4);
    localparam logic [DATA_W-1:0] Y_AT_2  = DATA_W'((15 * ONE_Q15) / 16);
    localparam logic [DATA_W-1:0] Y_MAX   = DATA_W'(ONE_Q15 - 1);

    function automatic logic [DATA_W-1:0] sat_q15(input logic [DATA_W-1:0] m);
        return (m > Y_MAX) ? Y_MAX : m;
    endfunction

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] mag_y;

    // Segment slopes: 0.75 below 1.0, 0.1875 up to 2.0, 0.0625 up to 3.0.
    always_comb begin
        mag   = x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
        d     = '0;
        mag_y = '0;
        if (mag < ONE_U) begin
            mag_y = (mag >> 1) + (mag >> 2);
        end else if (mag < TWO_U) begin
            d     = mag - ONE_U;
            mag_y = Y_AT_1 + (d >> 3) + (d >> 4);
        end else if (mag < THREE_U) begin
            d     = mag - TWO_U;
            mag_y = Y_AT_2 + (d >> 4);
        end else begin
            mag_y = Y_MAX;
        end
        mag_y = sat_q15(mag_y);
        y     = x[DATA_W-1] ? -$signed(mag_y) : $signed(mag_y);
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first valid requester after ptr wins.
// Produces the one-hot grant and its encoded index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // ptr itself is visited last so the previous winner has lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/tanh_rr_arbiter.sv
// Shares one Tanh unit between N_REQ requesters: round-robin grant, operand
// register, Tanh, output register with backpressure; results tagged with requester ID.
module tanh_rr_arbiter
    import rnn_fixed_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = rnn_fixed_pkg::DATA_W,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_x,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_y,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    logic                     adv;
    logic                     s1_free;
    logic                     xfer;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          win_idx;
    logic signed [DATA_W-1:0] win_x;
    logic [ID_W-1:0]          ptr;

    logic                     vld_p1;
    logic signed [DATA_W-1:0] x_p1;
    logic [ID_W-1:0]          id_p1;
    logic signed [DATA_W-1:0] y_p1;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (win_idx)
    );

    always_comb begin
        win_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_x = req_x[i*DATA_W +: DATA_W];
            end
        end
    end

    assign adv       = !rsp_valid || rsp_ready;
    // rst_n gating keeps req_ready low for the whole reset window.
    assign s1_free   = rst_n && (!vld_p1 || adv);
    assign req_ready = s1_free ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign busy      = vld_p1 | rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            ptr       <= ID_W'(N_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else begin
            if (s1_free) begin
                vld_p1 <= xfer;
            end
            if (xfer) begin
                ptr <= win_idx;
            end
            if (adv) begin
                rsp_valid <= vld_p1;
                if (vld_p1) begin
                    rsp_y  <= y_p1;
                    rsp_id <= id_p1;
                end
            end
        end
    end

    // S1 operand/ID: qualified by vld_p1, so no reset needed.
    always_ff @(posedge clk) begin
        if (xfer) begin
            x_p1  <= win_x;
            id_p1 <= win_idx;
        end
    end

    Tanh #(
        .DATA_W (DATA_W)
    ) u_tanh (
        .x (x_p1),
        .y (y_p1)
    );

endmodule

// File: tb/tb_tanh_rr_arbiter.sv
// Directed bench for tanh_rr_arbiter: vector tables for single transfers,
// continuous round-robin, backpressure and fairness, plus an async mid-flight reset.
module tb_tanh_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_x;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_y;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;

    logic [31:0] xs [4];
    assign req_x = {xs[3], xs[2], xs[1], xs[0]};

    int n_checks = 0;
    int n_errors = 0;

    tanh_rr_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    typedef struct {
        logic [3:0] v;
        logic       rr;
        logic [3:0] rdy;
        logic       rv;
        int         id;
    } bp_t;

    typedef struct {
        logic       v3;
        logic [3:0] rdy;
    } fr_t;

    vec_t        vecs [11];
    bp_t         bp   [16];
    fr_t         fr   [10];
    logic [31:0] yq   [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_bp_x();
        xs[0] = 32'h0000_4000;
        xs[1] = 32'h0000_8000;
        xs[2] = 32'h0000_C000;
        xs[3] = 32'h0001_0000;
    endtask

    initial begin
        vecs[0]  = '{2, 32'h0000_8000, 32'h0000_6000};
        vecs[1]  = '{0, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1, 32'h0000_4000, 32'h0000_3000};
        vecs[3]  = '{3, 32'h0004_0000, 32'h0000_7FFF};
        vecs[4]  = '{2, 32'hFFFC_0000, 32'hFFFF_8001};
        vecs[5]  = '{0, 32'h0001_0000, 32'h0000_7800};
        vecs[6]  = '{1, 32'hFFFF_8000, 32'hFFFF_A000};
        vecs[7]  = '{3, 32'h0000_C000, 32'h0000_6C00};
        vecs[8]  = '{2, 32'h0001_4000, 32'h0000_7C00};
        vecs[9]  = '{0, 32'hFFFF_C000, 32'hFFFF_D000};
        vecs[10] = '{1, 32'h0001_8000, 32'h0000_7FFF};

        yq[0] = 32'h0000_3000;
        yq[1] = 32'h0000_6000;
        yq[2] = 32'h0000_6C00;
        yq[3] = 32'h0000_7800;

        bp[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 0};
        bp[1]  = '{4'hF, 1'b0, 4'h2, 1'b0, 0};
        bp[2]  = '{4'hF, 1'b0, 4'h0, 1'b1, 0};
        bp[3]  = '{4'hF, 1'b0, 4'h0, 1'b1, 0};
        bp[4]  = '{4'hF, 1'b0, 4'h0, 1'b1, 0};
        bp[5]  = '{4'hF, 1'b1, 4'h4, 1'b1, 0};
        bp[6]  = '{4'hF, 1'b1, 4'h8, 1'b1, 1};
        bp[7]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2};
        bp[8]  = '{4'hF, 1'b1, 4'h2, 1'b1, 3};
        bp[9]  = '{4'hF, 1'b1, 4'h4, 1'b1, 0};
        bp[10] = '{4'hF, 1'b1, 4'h8, 1'b1, 1};
        bp[11] = '{4'hF, 1'b1, 4'h1, 1'b1, 2};
        bp[12] = '{4'hF, 1'b1, 4'h2, 1'b1, 3};
        bp[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 0};
        bp[14] = '{4'h0, 1'b1, 4'h0, 1'b1, 1};
        bp[15] = '{4'h0, 1'b1, 4'h0, 1'b0, 0};

        fr[0] = '{1'b1, 4'h1};
        fr[1] = '{1'b1, 4'h8};
        fr[2] = '{1'b0, 4'h1};
        fr[3] = '{1'b1, 4'h8};
        fr[4] = '{1'b0, 4'h1};
        fr[5] = '{1'b1, 4'h8};
        fr[6] = '{1'b1, 4'h1};
        fr[7] = '{1'b1, 4'h8};
        fr[8] = '{1'b1, 4'h1};
        fr[9] = '{1'b1, 4'h8};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) xs[i] = '0;

        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_y", rsp_y, 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single requester transfers, two-cycle latency each.
        for (int i = 0; i < 11; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << vecs[i].id;
            xs[vecs[i].id] = vecs[i].x;
            req_valid = oh;
            rsp_ready = 1'b1;
            #1;
            check("single_ready", 32'(req_ready), 32'(oh));
            tick();
            req_valid = '0;
            #1;
            check("single_lat1_valid", 32'(rsp_valid), 32'h0);
            check("single_lat1_busy", 32'(busy), 32'h1);
            tick();
            check("single_valid", 32'(rsp_valid), 32'h1);
            check("single_id", 32'(rsp_id), 32'(vecs[i].id));
            check("single_y", rsp_y, vecs[i].y);
            tick();
            check("single_after_valid", 32'(rsp_valid), 32'h0);
        end

        // All requesters continuously valid: 0,1,2,3,0,... one per cycle.
        do_reset();
        set_bp_x();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("cont_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c < 2) begin
                check("cont_rsp_valid_lo", 32'(rsp_valid), 32'h0);
            end else begin
                check("cont_rsp_valid", 32'(rsp_valid), 32'h1);
                check("cont_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
                check("cont_rsp_y", rsp_y, yq[(c - 2) % 4]);
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();

        // Backpressure then release and drain.
        do_reset();
        set_bp_x();
        for (int c = 0; c < 16; c++) begin
            req_valid = bp[c].v;
            rsp_ready = bp[c].rr;
            #1;
            check("bp_ready", 32'(req_ready), 32'(bp[c].rdy));
            check("bp_rsp_valid", 32'(rsp_valid), 32'(bp[c].rv));
            if (bp[c].rv) begin
                check("bp_rsp_id", 32'(rsp_id), 32'(bp[c].id));
                check("bp_rsp_y", rsp_y, yq[bp[c].id]);
            end
            tick();
        end
        check("bp_idle_busy", 32'(busy), 32'h0);

        // Reset while S1 and S2 are both full.
        do_reset();
        set_bp_x();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("mf_pre_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mf_pre_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mf_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mf_rsp_y", rsp_y, 32'h0);
        check("mf_rsp_id", 32'(rsp_id), 32'h0);
        check("mf_busy", 32'(busy), 32'h0);
        check("mf_req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        #1;
        check("mf_in_reset_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mf_first_grant", 32'(req_ready), 32'h2);
        tick();
        check("mf_second_grant", 32'(req_ready), 32'h8);
        check("mf_no_stale_rsp", 32'(rsp_valid), 32'h0);
        tick();
        check("mf_rsp_valid_after", 32'(rsp_valid), 32'h1);
        check("mf_rsp_id_after", 32'(rsp_id), 32'h1);
        check("mf_rsp_y_after", rsp_y, 32'h0000_6000);
        req_valid = '0;
        tick();
        tick();
        tick();

        // Fairness: requester 0 always valid, requester 3 toggling.
        begin
            int wait_cnt;
            int max_wait;
            wait_cnt = 0;
            max_wait = 0;
            do_reset();
            xs[0] = 32'h0000_8000;
            xs[3] = 32'h0000_4000;
            rsp_ready = 1'b1;
            for (int c = 0; c < 10; c++) begin
                req_valid = {fr[c].v3, 3'b001};
                #1;
                check("fair_ready", 32'(req_ready), 32'(fr[c].rdy));
                if (fr[c].v3 && req_ready[3]) begin
                    if (wait_cnt > max_wait) max_wait = wait_cnt;
                    wait_cnt = 0;
                end else if (fr[c].v3 && |req_ready) begin
                    wait_cnt++;
                end
                tick();
            end
            check("fair_max_wait_le2", 32'(max_wait <= 2), 32'h1);
            req_valid = '0;
            tick();
            tick();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
